// File: rtl/led_page_sequencer_if.sv
// Board-side bundle for led_page_sequencer: raw pins and page data in, synced switches, LEDs and step pulse out.
// master = board/problem side that drives the pins, slave = the sequencer.
interface led_page_sequencer_if #(
   parameter int NUM_PAGES = 4
);
   logic [7:0]             switch_raw;
   logic                   btn_raw;
   logic                   auto_mode;
   logic [NUM_PAGES*4-1:0] page_data;
   logic [7:0]             switch;
   logic [7:0]             led;
   logic                   btn_step;

   modport master (
      output switch_raw,
      output btn_raw,
      output auto_mode,
      output page_data,
      input  switch,
      input  led,
      input  btn_step
   );

   modport slave (
      input  switch_raw,
      input  btn_raw,
      input  auto_mode,
      input  page_data,
      output switch,
      output led,
      output btn_step
   );
endinterface

// File: rtl/led_page_sequencer.sv
// Multiplexes up to 16 four-bit result pages onto 8 LEDs, paged by a debounced button or an auto-scan timer.
// Optional macro LED_CHANGE_FLASH_EN blanks led[3:0] for FLASH_CYCLES cycles after every page advance.
module led_page_sequencer #(
   parameter int NUM_PAGES       = 4,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int SCAN_CYCLES     = 25000000,
   parameter int FLASH_CYCLES    = 1000000
) (
   input  logic                  clk,
   input  logic                  rst,
   led_page_sequencer_if.slave   bus
);

   localparam logic [15:0] DBC_LAST  = 16'(DEBOUNCE_CYCLES - 1);
   localparam logic [31:0] SCAN_LAST = 32'(SCAN_CYCLES - 1);
   localparam logic [3:0]  PAGE_LAST = 4'(NUM_PAGES - 1);

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      PRESSED,
      RELEASE_WAIT
   } db_state_t;

   logic [7:0]  sw_meta;
   logic [7:0]  sw_sync;
   logic        btn_meta;
   logic        btn_s;
   db_state_t   db_state;
   logic [15:0] dbc;
   logic        btn_step_reg;
   logic [31:0] scnt;
   logic [3:0]  page;
   logic [7:0]  led_reg;
   logic        scan_tick;
   logic        advance;
   logic        blank;
   logic [3:0]  page_nibble;
   logic [3:0]  nib [16];

   // Plain two-flop synchronizers; the switches are deliberately not debounced.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sw_meta  <= 8'h00;
         sw_sync  <= 8'h00;
         btn_meta <= 1'b0;
         btn_s    <= 1'b0;
      end else begin
         sw_meta  <= bus.switch_raw;
         sw_sync  <= sw_meta;
         btn_meta <= bus.btn_raw;
         btn_s    <= btn_meta;
      end
   end

   // Debounce: a press needs DEBOUNCE_CYCLES stable-high cycles, a release the same stable-low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         db_state     <= IDLE;
         dbc          <= 16'd0;
         btn_step_reg <= 1'b0;
      end else begin
         btn_step_reg <= 1'b0;
         case (db_state)
            IDLE: begin
               if (btn_s) begin
                  db_state <= PRESS_WAIT;
                  dbc      <= 16'd0;
               end
            end
            PRESS_WAIT: begin
               if (!btn_s) begin
                  db_state <= IDLE;
               end else if (dbc == DBC_LAST) begin
                  db_state     <= PRESSED;
                  btn_step_reg <= 1'b1;
               end else begin
                  dbc <= dbc + 16'd1;
               end
            end
            PRESSED: begin
               if (!btn_s) begin
                  db_state <= RELEASE_WAIT;
                  dbc      <= 16'd0;
               end
            end
            RELEASE_WAIT: begin
               if (btn_s) begin
                  db_state <= PRESSED;
               end else if (dbc == DBC_LAST) begin
                  db_state <= IDLE;
               end else begin
                  dbc <= dbc + 16'd1;
               end
            end
            default: db_state <= IDLE;
         endcase
      end
   end

   assign scan_tick = bus.auto_mode && (scnt == SCAN_LAST);
   assign advance   = btn_step_reg || scan_tick;

   // A manual step restarts the dwell so the operator gets a full period on the chosen page.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scnt <= 32'd0;
      end else if (!bus.auto_mode || advance) begin
         scnt <= 32'd0;
      end else begin
         scnt <= scnt + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         page <= 4'd0;
      end else if (advance) begin
         page <= (page == PAGE_LAST) ? 4'd0 : page + 4'd1;
      end
   end

   // Unpopulated page slots read as zero so any 4-bit page value selects something defined.
   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_nib
         if (gi < NUM_PAGES) begin : g_used
            assign nib[gi] = bus.page_data[4*gi +: 4];
         end else begin : g_unused
            assign nib[gi] = 4'h0;
         end
      end
   endgenerate

   assign page_nibble = nib[page];

`ifdef LED_CHANGE_FLASH_EN
   localparam logic [31:0] FLASH_LOAD = 32'(FLASH_CYCLES);

   logic [31:0] fcnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fcnt <= 32'd0;
      end else if (advance) begin
         fcnt <= FLASH_LOAD;
      end else if (fcnt != 32'd0) begin
         fcnt <= fcnt - 32'd1;
      end
   end

   assign blank = (fcnt != 32'd0);
`else
   // Never blanks without the flash feature.
   assign blank = (FLASH_CYCLES < 0);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         led_reg <= 8'h00;
      end else begin
         led_reg <= {page, blank ? 4'h0 : page_nibble};
      end
   end

   assign bus.switch   = sw_sync;
   assign bus.led      = led_reg;
   assign bus.btn_step = btn_step_reg;

endmodule

// File: doc/led_page_sequencer.md
Name: led_page_sequencer

Overview:
- Shares the board's 8 LEDs between up to 16 lab-problem result "pages" (4 bits each). A debounced push-button or an auto-scan timer selects the displayed page.
- Also synchronizes the raw slide switches before they are fanned out to the problem logic.
- Sits between the board I/O pins and the combinational problem modules, which consume `switch` and produce `page_data`.

Parameters:
- NUM_PAGES, 4: number of result pages; legal range 2..16.
- DEBOUNCE_CYCLES, 50000: number of cycles the synchronized button must stay stable to register a press or release; range 2..65535.
- SCAN_CYCLES, 25000000: auto-scan dwell time per page, in cycles; must be ≥2; counter is 32 bits.
- FLASH_CYCLES, 1000000: blank duration after a page change; used only with LED_CHANGE_FLASH_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- switch_raw  in  8  raw slide switches
- btn_raw  in  1  raw push-button, active high
- auto_mode  in  1  synchronous to clk; 1 = auto-scan pages
- page_data  in  NUM_PAGES*4  page p occupies bits [4p+3:4p]
- switch  out  8  synchronized switches
- led  out  8  [7:4] = current page index, [3:0] = that page's data
- btn_step  out  1  one-cycle pulse for each debounced press

Behaviour:
- Reset: asynchronous, active-high. All flops clear: switch=0, led=0, btn_step=0, page=0, debounce FSM=IDLE, debounce counter=0, scan counter=0.
- Switch path: two-flop synchronizer per bit. `switch` reflects `switch_raw` 2 clk edges after it changes. No debounce on this path.
- Button path: 2-flop synchronizer produces btn_s. 16-bit counter dbc. FSM:
  - IDLE: btn_s=1 → PRESS_WAIT, dbc=0.
  - PRESS_WAIT: btn_s=0 → IDLE. Otherwise dbc++. When dbc==DEBOUNCE_CYCLES-1 → PRESSED, and btn_step=1 on that cycle only.
  - PRESSED: btn_s=0 → RELEASE_WAIT, dbc=0.
  - RELEASE_WAIT: btn_s=1 → PRESSED with no new step. When dbc==DEBOUNCE_CYCLES-1 → IDLE.
- Step latency: btn_step asserts on the edge after exactly DEBOUNCE_CYCLES consecutive cycles in PRESS_WAIT. Holding the button produces one step; glitches shorter than the window produce none.
- Page register: 4 bits.
  - Advances when btn_step=1 or a scan tick occurs.
  - Wraps NUM_PAGES-1 → 0.
  - A step and a scan tick on the same cycle cause a single advance.
- Auto-scan counter scnt:
  - Counts only while auto_mode=1.
  - At scnt==SCAN_CYCLES-1: generate a tick and set scnt=0.
  - btn_step in auto mode: advance the page and clear scnt, restarting the dwell.
  - auto_mode=0: scnt held at 0 and the page holds.
- LED output: registered, led = {page, page_data[4*page+3 -: 4]}. Updates 1 cycle after a page or page_data change.
- Reset mid-press: FSM returns to IDLE. A still-held button after reset must first satisfy the PRESS_WAIT window, so it produces a step once debounced.

Optional Feature:
- Macro: LED_CHANGE_FLASH_EN.
- Defined:
  - After every page advance, led[3:0] is forced to 0000 for FLASH_CYCLES cycles; led[7:4] shows the new page immediately.
  - A further advance during blanking restarts the blank window.
  - Flash counter resets to 0 (not blanking).
- Undefined: no flash counter is synthesized; led[3:0] always shows page data.

Test Plan (NUM_PAGES=4, DEBOUNCE_CYCLES=4, SCAN_CYCLES=8, FLASH_CYCLES=3):
- Reset, then switch_raw=8'hA5 → switch=8'hA5 on the 2nd edge after the change; led=8'h00 during and after reset with page_data=0.
- page_data=16'h4321; btn_raw held high 20 cycles → exactly one btn_step; led goes 8'h01 → 8'h12. Four total presses → led returns to 8'h01 (wrap).
- btn_raw pulses high for 3 cycles, repeated 5 times → btn_step never asserts; led unchanged.
- auto_mode=1 from page 0 → page advances every 8 cycles: 0,1,2,3,0. A press mid-dwell advances the page and the next auto advance comes 8 cycles later; a press coinciding with a tick advances exactly once.
- rst asserted during PRESS_WAIT (dbc=2) → outputs clear immediately without waiting for clk; with btn_raw still high, btn_step occurs only after a full window.
- LED_CHANGE_FLASH_EN defined, one press → led[3:0]=0 for 3 cycles while led[7:4]=1, then led=8'h12.
